cv32e41s_register_file_ecc_scrub: RTL and testbench
===================================================

// Module: cv32e41s_register_file_ecc_scrub
// PURPOSE
// - Flop-based integer register file with per-word SECDED ECC and a background scrubber.
// - Generalises the ECC register file wrapper:
//   - parametrised read/write port count, word count and data width.
//   - single-bit errors are corrected on every read port.
//   - an idle-time scrubber FSM walks all words and writes corrected data back.
// - Sits in ID/WB, replacing the register file plus ECC pair in SECURE configurations.
// PARAMETERS
// - NUM_READ_PORTS   2   read ports, 1..3
// - NUM_WRITE_PORTS  1   write ports, 1..2; a higher index wins on equal waddr
// - NUM_WORDS        32  32 for RV32I, 16 for RV32E; word 0 is x0
// - DATA_WIDTH       32  data bits per word
// - SCRUB_INTERVAL   64  idle cycles between scrub accesses, >=1
// - ECC_WIDTH (localparam) = smallest k with 2^k >= DATA_WIDTH+k+1, plus 1 overall parity bit (7 for 32)
// PORTS
// - clk             in   1                  clock
// - rst_n           in   1                  async active-low reset
// - raddr_i[NRP]    in   clog2(NUM_WORDS)   read addresses
// - rdata_o[NRP]    out  DATA_WIDTH         corrected read data
// - waddr_i[NWP]    in   clog2(NUM_WORDS)   write addresses
// - wdata_i[NWP]    in   DATA_WIDTH         write data, unencoded
// - we_i[NWP]       in   1                  write enables
// - scrub_en_i      in   1                  enables the scrubber
// - ecc_corr_o      out  1                  single-bit error on any read port, this cycle
// - ecc_err_o       out  1                  double-bit error on any read port, this cycle
// - scrub_corr_o    out  1                  1-cycle pulse when the scrubber writes back a correction
// - scrub_uncorr_o  out  1                  sticky; scrubber found a double-bit error; cleared only by reset
// - scrub_addr_o    out  clog2(NUM_WORDS)   current scrub pointer
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - all words = encode(0), which has valid ECC.
//   - FSM = IDLE, interval counter = 0, scrub pointer = 1.
//   - scrub_corr_o = 0, scrub_uncorr_o = 0.
//   - Reset mid-scrub abandons any pending write-back.
// - Write:
//   - on the clk edge, word[waddr] <= {encode(wdata), wdata}.
//   - Writes to word 0 are ignored.
//   - Reads in the same cycle return the old contents (no bypass).
// - Read (combinational):
//   - decode word[raddr]; single-bit errors (data or check bit) are corrected in rdata_o and raise ecc_corr_o.
//   - double-bit errors raise ecc_err_o; rdata_o = raw data bits.
//   - raddr=0 returns 0 with no flags.
// - Scrubber FSM:
//   - IDLE:
//     - while scrub_en_i=1, count up; at SCRUB_INTERVAL-1 -> READ, counter cleared.
//     - while scrub_en_i=0, counter held at 0.
//   - READ (1 cycle):
//     - decode word[ptr] on an internal read port; register the corrected word and the error class.
//     - go to FIX.
//   - FIX (1 cycle), by registered error class:
//     - single: write the corrected encoded word to word[ptr] and pulse scrub_corr_o.
//     - double: set scrub_uncorr_o; no write.
//     - none: no write.
//     - In all cases ptr <= ptr+1, with NUM_WORDS-1 wrapping to 1; then -> IDLE.
// - Priority and collision:
//   - functional writes always win.
//   - any we_i to ptr during READ or FIX cancels the scrub write-back and suppresses scrub_corr_o/scrub_uncorr_o for that word; ptr still advances.
//   - a scrub write never blocks or delays a functional write or read.
// - scrub_en_i deasserted in READ or FIX: the access in flight completes; the FSM then stays in IDLE.
// - Read ports never see scrub-written data until the edge after FIX.
// TESTING
// - Write x5=0xDEADBEEF, flip data bit 3 via force -> read returns 0xDEADBEEF, ecc_corr_o=1.
// - Flip bits 3 and 17 of x7 -> ecc_err_o=1, ecc_corr_o=0.
//   - with the scrubber enabled, once ptr reaches 7 scrub_uncorr_o sets and stays set until reset.
// - SCRUB_INTERVAL=4, scrub_en_i=1, single-bit flip in x9:
//   - FIX reaches x9 -> scrub_corr_o pulses once.
//   - subsequent reads of x9 give ecc_corr_o=0.
//   - ptr wraps 31 -> 1.
// - Functional we_i to x9 with 0x1234 during the scrub FIX of x9 -> x9=0x1234, no scrub_corr_o, ptr=10.
// - Assert rst_n low during READ -> all flags 0, ptr=1, all reads return 0 with no errors.

Source files
------------

// File: rtl/cv32e41s_register_file_ecc_scrub.sv
// -----------------------------------------------------------------------------
// cv32e41s_register_file_ecc_scrub
//
// Flop-based integer register file. Every word is stored with a SECDED code,
// laid out as {overall_parity, hamming_check[K-1:0], data[DATA_WIDTH-1:0]}.
// Read ports decode combinationally: single-bit errors are corrected, and
// double-bit errors are flagged with the raw data passed through. While the
// scrubber is enabled and the interval expires, a background scrubber
// re-reads one word and writes the corrected code word back.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   raddr_i/rdata_o  read address / corrected read data, one per read port
//   waddr_i/wdata_i  write address / unencoded write data, one per write port
//   we_i             write enable, one per write port (higher index wins)
//   scrub_en_i       enables the background scrubber
//   ecc_corr_o       single-bit error seen on any read port this cycle
//   ecc_err_o        double-bit error seen on any read port this cycle
//   scrub_corr_o     one-cycle pulse after the scrubber wrote back a correction
//   scrub_uncorr_o   sticky: scrubber met a double-bit error (reset clears it)
//   scrub_addr_o     current scrub pointer
// -----------------------------------------------------------------------------
module cv32e41s_register_file_ecc_scrub #(
    parameter int unsigned NUM_READ_PORTS  = 2,
    parameter int unsigned NUM_WRITE_PORTS = 1,
    parameter int unsigned NUM_WORDS       = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SCRUB_INTERVAL  = 64,
    localparam int unsigned ADDR_WIDTH     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] raddr_i [NUM_READ_PORTS],
    output logic [DATA_WIDTH-1:0] rdata_o [NUM_READ_PORTS],
    input  logic [ADDR_WIDTH-1:0] waddr_i [NUM_WRITE_PORTS],
    input  logic [DATA_WIDTH-1:0] wdata_i [NUM_WRITE_PORTS],
    input  logic                  we_i    [NUM_WRITE_PORTS],
    input  logic                  scrub_en_i,
    output logic                  ecc_corr_o,
    output logic                  ecc_err_o,
    output logic                  scrub_corr_o,
    output logic                  scrub_uncorr_o,
    output logic [ADDR_WIDTH-1:0] scrub_addr_o
);

    // Smallest k with 2^k >= dw + k + 1.
    function automatic int unsigned calc_k(input int unsigned dw);
        int unsigned k;
        k = 0;
        for (int unsigned j = 1; j < 32; j++) begin
            if ((k == 0) && ((32'd1 << j) >= (dw + j + 32'd1))) begin
                k = j;
            end
        end
        return k;
    endfunction

    localparam int unsigned K          = calc_k(DATA_WIDTH);
    localparam int unsigned ECC_WIDTH  = K + 1;
    localparam int unsigned CODE_LEN   = DATA_WIDTH + K;
    localparam int unsigned WORD_WIDTH = DATA_WIDTH + ECC_WIDTH;
    localparam int unsigned CNT_WIDTH  = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(SCRUB_INTERVAL - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_FIRST = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(NUM_WORDS - 1);

    // Hamming position (1-based) of data bit idx; powers of two hold check bits.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned cnt;
        int unsigned p;
        cnt = 0;
        p   = 0;
        for (int unsigned q = 1; q <= CODE_LEN; q++) begin
            if ((q & (q - 32'd1)) != 32'd0) begin
                if (cnt == idx) begin
                    p = q;
                end
                cnt = cnt + 32'd1;
            end
        end
        return p;
    endfunction

    // Hamming check bits over the data bits.
    function automatic logic [K-1:0] calc_chk(input logic [DATA_WIDTH-1:0] data);
        logic [K-1:0] chk;
        int unsigned  p;
        chk = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            p = data_pos(i);
            for (int unsigned b = 0; b < K; b++) begin
                if (p[b]) begin
                    chk[b] = chk[b] ^ data[i];
                end
            end
        end
        return chk;
    endfunction

    // Check field {overall parity, hamming bits}; overall parity makes the whole word even.
    function automatic logic [ECC_WIDTH-1:0] ecc_encode(input logic [DATA_WIDTH-1:0] data);
        logic [K-1:0] chk;
        chk = calc_chk(data);
        return {(^data) ^ (^chk), chk};
    endfunction

    // Returns {double_err, single_corr, data}; data is corrected for single errors, raw otherwise.
    function automatic logic [DATA_WIDTH+1:0] ecc_decode(input logic [WORD_WIDTH-1:0] word);
        logic [DATA_WIDTH-1:0] data;
        logic [K-1:0]          syn;
        logic                  overall;
        logic                  corr;
        logic                  err;
        logic                  hit;
        data    = word[DATA_WIDTH-1:0];
        syn     = word[DATA_WIDTH +: K] ^ calc_chk(data);
        overall = ^word;
        corr    = 1'b0;
        err     = 1'b0;
        hit     = 1'b0;
        if (overall) begin
            // Syndrome 0 means the overall bit flipped, a power of two means a check bit.
            if ((syn & (syn - K'(1))) == '0) begin
                corr = 1'b1;
            end else begin
                for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                    if (data_pos(i) == 32'(syn)) begin
                        data[i] = ~data[i];
                        hit     = 1'b1;
                    end
                end
                // A syndrome pointing past the code word cannot be a single error.
                corr = hit;
                err  = ~hit;
            end
        end else begin
            err = (syn != '0);
        end
        return {err, corr, data};
    endfunction

    localparam logic [WORD_WIDTH-1:0] RESET_WORD = {ecc_encode(DATA_WIDTH'(0)), DATA_WIDTH'(0)};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_FIX  = 2'd2
    } scrub_state_e;

    logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] mem_q;
    logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] mem_d;
    logic [DATA_WIDTH+1:0]                rd_dec_s [NUM_READ_PORTS];
    logic                                 rd_corr_s;
    logic                                 rd_err_s;

    scrub_state_e          state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [DATA_WIDTH-1:0] sc_data_q;
    logic                  sc_corr_q;
    logic                  sc_err_q;
    logic                  cancel_q;
    logic                  scrub_corr_q;
    logic                  scrub_uncorr_q;

    logic [DATA_WIDTH+1:0] sc_dec_s;
    logic                  wr_hit_s;
    logic                  fix_cancel_s;
    logic                  scrub_wr_s;
    logic [WORD_WIDTH-1:0] scrub_word_s;

    // Read ports: decode, correct, and merge error flags; x0 always reads zero.
    always_comb begin
        rd_corr_s = 1'b0;
        rd_err_s  = 1'b0;
        for (int r = 0; r < NUM_READ_PORTS; r++) begin
            rd_dec_s[r] = ecc_decode(mem_q[raddr_i[r]]);
            if (raddr_i[r] == '0) begin
                rdata_o[r] = '0;
            end else begin
                rdata_o[r] = rd_dec_s[r][DATA_WIDTH-1:0];
                rd_corr_s  = rd_corr_s | rd_dec_s[r][DATA_WIDTH];
                rd_err_s   = rd_err_s  | rd_dec_s[r][DATA_WIDTH+1];
            end
        end
    end

    // Scrubber side: internal read port, collision detect, write-back word.
    always_comb begin
        sc_dec_s = ecc_decode(mem_q[ptr_q]);
        wr_hit_s = 1'b0;
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            wr_hit_s = wr_hit_s | (we_i[w] && (waddr_i[w] == ptr_q));
        end
        // A functional write to the scrubbed word in READ or FIX invalidates the scrub result.
        fix_cancel_s = cancel_q | wr_hit_s;
        scrub_wr_s   = (state_q == S_FIX) && sc_corr_q && !fix_cancel_s;
        scrub_word_s = {ecc_encode(sc_data_q), sc_data_q};
    end

    // Next memory contents: scrub write first, functional writes override it.
    always_comb begin
        mem_d        = mem_q;
        mem_d[ptr_q] = scrub_wr_s ? scrub_word_s : mem_q[ptr_q];
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            mem_d[waddr_i[w]] = (we_i[w] && (waddr_i[w] != '0)) ?
                                {ecc_encode(wdata_i[w]), wdata_i[w]} : mem_d[waddr_i[w]];
        end
    end

    // Storage flops; word 0 keeps its reset value forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= {NUM_WORDS{RESET_WORD}};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Scrubber FSM with its registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            ptr_q          <= PTR_FIRST;
            sc_data_q      <= '0;
            sc_corr_q      <= 1'b0;
            sc_err_q       <= 1'b0;
            cancel_q       <= 1'b0;
            scrub_corr_q   <= 1'b0;
            scrub_uncorr_q <= 1'b0;
        end else begin
            scrub_corr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (scrub_en_i) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_READ;
                        end else begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                S_READ: begin
                    sc_data_q <= sc_dec_s[DATA_WIDTH-1:0];
                    sc_corr_q <= sc_dec_s[DATA_WIDTH];
                    sc_err_q  <= sc_dec_s[DATA_WIDTH+1];
                    cancel_q  <= wr_hit_s;
                    state_q   <= S_FIX;
                end
                S_FIX: begin
                    if (!fix_cancel_s) begin
                        scrub_corr_q   <= sc_corr_q;
                        scrub_uncorr_q <= scrub_uncorr_q | sc_err_q;
                    end else begin
                        scrub_uncorr_q <= scrub_uncorr_q;
                    end
                    ptr_q    <= (ptr_q == PTR_LAST) ? PTR_FIRST : (ptr_q + ADDR_WIDTH'(1));
                    cancel_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign ecc_corr_o     = rd_corr_s;
    assign ecc_err_o      = rd_err_s;
    assign scrub_corr_o   = scrub_corr_q;
    assign scrub_uncorr_o = scrub_uncorr_q;
    assign scrub_addr_o   = ptr_q;

endmodule

// File: tb/tb_cv32e41s_register_file_ecc_scrub.sv
// -----------------------------------------------------------------------------
// Directed testbench for cv32e41s_register_file_ecc_scrub (2 read ports,
// 2 write ports, 32 words, 32-bit data, scrub interval of 4 cycles).
// Bit errors are planted in the storage through force/release.
// -----------------------------------------------------------------------------
module tb_cv32e41s_register_file_ecc_scrub;

    logic        clk;
    logic        rst_n;
    logic [4:0]  raddr [2];
    logic [31:0] rdata [2];
    logic [4:0]  waddr [2];
    logic [31:0] wdata [2];
    logic        we    [2];
    logic        scrub_en;
    logic        ecc_corr;
    logic        ecc_err;
    logic        scrub_corr;
    logic        scrub_uncorr;
    logic [4:0]  scrub_addr;

    int tests;
    int fails;
    int pulses;
    logic [31:0][38:0] mem_v;

    cv32e41s_register_file_ecc_scrub #(
        .NUM_READ_PORTS  (2),
        .NUM_WRITE_PORTS (2),
        .NUM_WORDS       (32),
        .DATA_WIDTH      (32),
        .SCRUB_INTERVAL  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .raddr_i        (raddr),
        .rdata_o        (rdata),
        .waddr_i        (waddr),
        .wdata_i        (wdata),
        .we_i           (we),
        .scrub_en_i     (scrub_en),
        .ecc_corr_o     (ecc_corr),
        .ecc_err_o      (ecc_err),
        .scrub_corr_o   (scrub_corr),
        .scrub_uncorr_o (scrub_uncorr),
        .scrub_addr_o   (scrub_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flip one stored bit of a word, leaving the rest untouched.
    task automatic flip(input logic [4:0] word, input logic [5:0] bitpos);
        mem_v = dut.mem_q;
        mem_v[word][bitpos] = ~mem_v[word][bitpos];
        force dut.mem_q = mem_v;
        #1;
        release dut.mem_q;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        we[p]    = 1'b1;
        waddr[p] = a;
        wdata[p] = d;
        @(negedge clk);
        we[p]    = 1'b0;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        raddr[p] = a;
        #1;
    endtask

    // Advance negedge by negedge until the scrub pointer hits target, counting pulses.
    task automatic step_until(input logic [4:0] target);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (scrub_corr) pulses++;
            if (scrub_addr == target) break;
        end
        check("ptr_reach", 32'(scrub_addr), 32'(target));
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        pulses   = 0;
        rst_n    = 1'b0;
        scrub_en = 1'b0;
        raddr[0] = 5'd0; raddr[1] = 5'd0;
        waddr[0] = 5'd0; waddr[1] = 5'd0;
        wdata[0] = 32'd0; wdata[1] = 32'd0;
        we[0]    = 1'b0; we[1]    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rd(0, 5'd5);
        check("rst_rdata", rdata[0], 32'h0);
        check("rst_corr", 32'(ecc_corr), 32'd0);
        check("rst_err", 32'(ecc_err), 32'd0);
        check("rst_ptr", 32'(scrub_addr), 32'd1);
        check("rst_scorr", 32'(scrub_corr), 32'd0);
        check("rst_suncorr", 32'(scrub_uncorr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Same-cycle read returns old contents, new data visible after the edge
        we[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 32'hDEADBEEF;
        rd(0, 5'd5);
        check("no_bypass", rdata[0], 32'h0);
        @(negedge clk);
        we[0] = 1'b0;
        rd(0, 5'd5);
        check("wr_x5", rdata[0], 32'hDEADBEEF);
        check("wr_x5_corr", 32'(ecc_corr), 32'd0);

        // Both ports write x3: higher port wins; port 0 also not blocking
        we[0] = 1'b1; waddr[0] = 5'd3; wdata[0] = 32'h00001111;
        we[1] = 1'b1; waddr[1] = 5'd3; wdata[1] = 32'h00002222;
        @(negedge clk);
        we[0] = 1'b0; we[1] = 1'b0;
        rd(1, 5'd3);
        check("wr_prio", rdata[1], 32'h00002222);

        // Writes to x0 are ignored
        wr(0, 5'd0, 32'hFFFFFFFF);
        rd(0, 5'd0);
        check("x0_zero", rdata[0], 32'h0);

        wr(1, 5'd6, 32'h12345678);
        wr(0, 5'd7, 32'hCAFEF00D);
        wr(1, 5'd9, 32'h0000ABCD);

        // Single data-bit error in x5
        flip(5'd5, 6'd3);
        rd(0, 5'd5);
        rd(1, 5'd3);
        check("sec_x5", rdata[0], 32'hDEADBEEF);
        check("sec_x5_corr", 32'(ecc_corr), 32'd1);
        check("sec_x5_err", 32'(ecc_err), 32'd0);

        // Single check-bit error in x6 (hamming bit 2), seen on port 1
        flip(5'd6, 6'd34);
        rd(0, 5'd0);
        rd(1, 5'd6);
        check("sec_x6", rdata[1], 32'h12345678);
        check("sec_x6_corr", 32'(ecc_corr), 32'd1);

        // Double error in x7: raw data returned
        flip(5'd7, 6'd3);
        flip(5'd7, 6'd17);
        rd(0, 5'd7);
        rd(1, 5'd0);
        check("ded_x7", rdata[0], 32'hCAFCF005);
        check("ded_x7_err", 32'(ecc_err), 32'd1);
        check("ded_x7_corr", 32'(ecc_corr), 32'd0);

        // Single error in x9
        flip(5'd9, 6'd0);
        rd(0, 5'd9);
        check("sec_x9", rdata[0], 32'h0000ABCD);
        check("sec_x9_corr", 32'(ecc_corr), 32'd1);
        rd(0, 5'd0);

        // First scrub sweep: x5, x6, x9 corrected, x7 uncorrectable
        scrub_en = 1'b1;
        pulses   = 0;
        step_until(5'd7);
        check("suncorr_before_x7", 32'(scrub_uncorr), 32'd0);
        step_until(5'd8);
        check("suncorr_after_x7", 32'(scrub_uncorr), 32'd1);
        step_until(5'd10);
        check("scorr_pulses", 32'(pulses), 32'd3);
        scrub_en = 1'b0;

        rd(0, 5'd9);
        rd(1, 5'd5);
        check("scrubbed_x9", rdata[0], 32'h0000ABCD);
        check("scrubbed_x5", rdata[1], 32'hDEADBEEF);
        check("scrubbed_corr", 32'(ecc_corr), 32'd0);
        rd(1, 5'd6);
        check("scrubbed_x6_corr", 32'(ecc_corr), 32'd0);

        // Disabled scrubber holds the pointer
        repeat (20) @(negedge clk);
        check("idle_hold_ptr", 32'(scrub_addr), 32'd10);

        // Rewriting x7 does not clear the sticky flag
        wr(0, 5'd7, 32'h00000007);
        rd(0, 5'd7);
        check("x7_rewrite", rdata[0], 32'h00000007);
        check("x7_rewrite_err", 32'(ecc_err), 32'd0);
        check("suncorr_sticky", 32'(scrub_uncorr), 32'd1);

        // Second sweep: pointer wraps 31 -> 1
        flip(5'd9, 6'd5);
        scrub_en = 1'b1;
        step_until(5'd31);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (scrub_addr != 5'd31) break;
        end
        check("ptr_wrap", 32'(scrub_addr), 32'd1);

        // Functional write to x9 during the scrub FIX of x9 cancels the write-back
        step_until(5'd9);
        repeat (5) @(negedge clk);
        we[0] = 1'b1; waddr[0] = 5'd9; wdata[0] = 32'h00001234;
        @(negedge clk);
        we[0] = 1'b0;
        rd(0, 5'd9);
        check("coll_ptr", 32'(scrub_addr), 32'd10);
        check("coll_scorr", 32'(scrub_corr), 32'd0);
        check("coll_x9", rdata[0], 32'h00001234);
        check("coll_x9_corr", 32'(ecc_corr), 32'd0);
        check("coll_suncorr", 32'(scrub_uncorr), 32'd1);

        // Reset while the scrubber is in READ on a corrupted x12
        flip(5'd12, 6'd8);
        step_until(5'd12);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        rd(0, 5'd12);
        rd(1, 5'd5);
        check("mid_rst_ptr", 32'(scrub_addr), 32'd1);
        check("mid_rst_scorr", 32'(scrub_corr), 32'd0);
        check("mid_rst_suncorr", 32'(scrub_uncorr), 32'd0);
        check("mid_rst_x12", rdata[0], 32'h0);
        check("mid_rst_x5", rdata[1], 32'h0);
        check("mid_rst_corr", 32'(ecc_corr), 32'd0);
        check("mid_rst_err", 32'(ecc_err), 32'd0);
        @(negedge clk);
        scrub_en = 1'b0;
        rst_n    = 1'b1;
        repeat (3) @(negedge clk);
        rd(0, 5'd12);
        check("post_rst_x12", rdata[0], 32'h0);
        check("post_rst_ptr", 32'(scrub_addr), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
